// File: rtl/runner_pkg.sv
// Shared lane encodings, game state and small helpers for the runner game core
// and its seven-segment display driver.
package runner_pkg;

  localparam logic [2:0] LANE_TOP     = 3'b100;
  localparam logic [2:0] LANE_MID     = 3'b010;
  localparam logic [2:0] LANE_BOT     = 3'b001;
  localparam logic [2:0] LANE_NONE    = 3'b000;
  localparam logic [2:0] PLAYER_RESET = LANE_MID;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } game_state_t;

  typedef struct packed {
    logic [3:0] minute_tens;
    logic [3:0] minute_ones;
    logic [3:0] second_tens;
    logic [3:0] second_ones;
  } bcd_time_t;

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // A nonzero column is always followed by an empty one, and a full column is
  // never spawned, so the player always has a way through.
  function automatic logic [2:0] spawn_lanes(input logic [2:0] cur_col,
                                             input logic [2:0] rnd);
    if (cur_col != LANE_NONE) return LANE_NONE;
    if (rnd == 3'b111)        return LANE_NONE;
    return rnd;
  endfunction

  function automatic bcd_time_t bcd_tick(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.second_ones != 4'd9) begin
      n.second_ones = t.second_ones + 4'd1;
    end else begin
      n.second_ones = 4'd0;
      if (t.second_tens != 4'd5) begin
        n.second_tens = t.second_tens + 4'd1;
      end else begin
        n.second_tens = 4'd0;
        if (t.minute_ones != 4'd9) begin
          n.minute_ones = t.minute_ones + 4'd1;
        end else begin
          n.minute_ones = 4'd0;
          if (t.minute_tens != 4'd5) n.minute_tens = t.minute_tens + 4'd1;
          else                       n = t;  // 59:59 saturates
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw push-button followed by a rising-edge detector
// that emits a single-cycle pulse per press.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn};
  end

  // NOTE: non-blocking assignments keep each stage a distinct flop; blocking
  // ones here would collapse the synchronizer into a single register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b000;
    else        sync_q <= sync_d;
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/runner_game_core.sv
// Game-state engine for the seven-segment runner: player lane, scrolling
// obstacles, collision detection and a saturating mm:ss survival timer.
module runner_game_core
  import runner_pkg::*;
#(
  parameter int unsigned SEC_DIV   = 100_000_000,
  parameter int unsigned STEP_DIV  = 50_000_000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_restart,
  output logic [2:0] obstacle1,
  output logic [2:0] obstacle2,
  output logic [2:0] obstacle3,
  output logic [2:0] obstacle4,
  output logic [2:0] player,
  output logic [3:0] second_ones,
  output logic [3:0] second_tens,
  output logic [3:0] minute_ones,
  output logic [3:0] minute_tens,
  output logic       game_over
);

  localparam int SEC_W  = (SEC_DIV  > 1) ? $clog2(SEC_DIV)  : 1;
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic up_pulse, down_pulse, restart_pulse;

  btn_edge u_btn_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .rise  (up_pulse)
  );

  btn_edge u_btn_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .rise  (down_pulse)
  );

  btn_edge u_btn_restart (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_restart),
    .rise  (restart_pulse)
  );

  game_state_t       state_q, state_d;
  logic [2:0]        player_q, player_d;
  logic [3:0][2:0]   obs_q, obs_d;  // [0] farthest column, [3] player column
  bcd_time_t         tmr_q, tmr_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;

  logic running, restart, step_pulse, sec_pulse;

  assign running    = (state_q == ST_RUN);
  assign restart    = (state_q == ST_OVER) && restart_pulse;
  assign step_pulse = running && (step_cnt_q == STEP_LAST);
  assign sec_pulse  = running && (sec_cnt_q == SEC_LAST);

  always_comb begin
    // NOTE: every *_d starts as its *_q so no branch leaves a value unassigned
    // and no latch can be inferred.
    state_d    = state_q;
    player_d   = player_q;
    obs_d      = obs_q;
    tmr_d      = tmr_q;
    lfsr_d     = lfsr_q;
    step_cnt_d = step_cnt_q;
    sec_cnt_d  = sec_cnt_q;

    if (restart) begin
      // The LFSR keeps running from where it froze, so each round differs.
      state_d    = ST_RUN;
      player_d   = PLAYER_RESET;
      obs_d      = '0;
      tmr_d      = '0;
      step_cnt_d = '0;
      sec_cnt_d  = '0;
    end else if (running) begin
      lfsr_d     = lfsr_next(lfsr_q);
      step_cnt_d = step_pulse ? '0 : step_cnt_q + STEP_W'(1);
      sec_cnt_d  = sec_pulse  ? '0 : sec_cnt_q + SEC_W'(1);

      if (step_pulse) begin
        obs_d = {obs_q[2:0], spawn_lanes(obs_q[0], lfsr_q[2:0])};
      end

      if (sec_pulse) begin
        tmr_d = bcd_tick(tmr_q);
      end

      if (up_pulse && !down_pulse && player_q != LANE_TOP) begin
        player_d = player_q << 1;
      end else if (down_pulse && !up_pulse && player_q != LANE_BOT) begin
        player_d = player_q >> 1;
      end

      if ((player_q & obs_q[3]) != LANE_NONE) begin
        state_d = ST_OVER;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      player_q   <= PLAYER_RESET;
      obs_q      <= '0;
      tmr_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      step_cnt_q <= '0;
      sec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      obs_q      <= obs_d;
      tmr_q      <= tmr_d;
      lfsr_q     <= lfsr_d;
      step_cnt_q <= step_cnt_d;
      sec_cnt_q  <= sec_cnt_d;
    end
  end

  assign obstacle1   = obs_q[0];
  assign obstacle2   = obs_q[1];
  assign obstacle3   = obs_q[2];
  assign obstacle4   = obs_q[3];
  assign player      = player_q;
  assign second_ones = tmr_q.second_ones;
  assign second_tens = tmr_q.second_tens;
  assign minute_ones = tmr_q.minute_ones;
  assign minute_tens = tmr_q.minute_tens;
  assign game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_runner_game_core.sv
// Directed bench for runner_game_core: a game instance with fast dividers and a
// fixed seed, plus a timer instance whose obstacles never reach the player.
module tb_runner_game_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       btn_up = 1'b0, btn_down = 1'b0, btn_restart = 1'b0;
  logic [2:0] obstacle1, obstacle2, obstacle3, obstacle4, player;
  logic [3:0] second_ones, second_tens, minute_ones, minute_tens;
  logic       game_over;

  logic       t_btn_up = 1'b0, t_btn_down = 1'b0, t_btn_restart = 1'b0;
  logic [2:0] t_obstacle1, t_obstacle2, t_obstacle3, t_obstacle4, t_player;
  logic [3:0] t_second_ones, t_second_tens, t_minute_ones, t_minute_tens;
  logic       t_game_over;

  int n_checks = 0;
  int n_fail   = 0;

  // Seed 8'h20 spawns 101 at steps 1, 3 and 5, then an LFSR value of 111 at
  // step 7, so a middle-lane player survives the first 40 cycles.
  runner_game_core #(
    .SEC_DIV   (10),
    .STEP_DIV  (4),
    .LFSR_SEED (8'h20)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_restart (btn_restart),
    .obstacle1   (obstacle1),
    .obstacle2   (obstacle2),
    .obstacle3   (obstacle3),
    .obstacle4   (obstacle4),
    .player      (player),
    .second_ones (second_ones),
    .second_tens (second_tens),
    .minute_ones (minute_ones),
    .minute_tens (minute_tens),
    .game_over   (game_over)
  );

  runner_game_core #(
    .SEC_DIV   (2),
    .STEP_DIV  (1_048_576)
  ) u_tmr (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up      (t_btn_up),
    .btn_down    (t_btn_down),
    .btn_restart (t_btn_restart),
    .obstacle1   (t_obstacle1),
    .obstacle2   (t_obstacle2),
    .obstacle3   (t_obstacle3),
    .obstacle4   (t_obstacle4),
    .player      (t_player),
    .second_ones (t_second_ones),
    .second_tens (t_second_tens),
    .minute_ones (t_minute_ones),
    .minute_tens (t_minute_tens),
    .game_over   (t_game_over)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released on a falling edge; the next rising edge is edge 1.
  task automatic do_reset();
    btn_up = 1'b0; btn_down = 1'b0; btn_restart = 1'b0;
    t_btn_up = 1'b0; t_btn_down = 1'b0; t_btn_restart = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst_n = 1'b0;
    tick(1);
    got = {obstacle1, obstacle2, obstacle3, obstacle4, player, game_over};
    n_checks++;
    if (got !== {12'h000, 3'b010, 1'b0}) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", got, {12'h000, 3'b010, 1'b0});
    end
    got = {minute_tens, minute_ones, second_tens, second_ones};
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++; $display("FAIL reset_timer: got %h expected 0000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(39);
    n_checks++;
    if (second_ones !== 4'd3) begin
      n_fail++; $display("FAIL timer_39: got %0d expected 3", second_ones);
    end
    tick(1);
    got = {minute_tens, minute_ones, second_tens, second_ones};
    n_checks++;
    if (got !== 16'h0004 || player !== 3'b010 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL timer_40: got %h/%b/%b expected 0004/010/0", got, player, game_over);
    end
  endtask

  // Player moves on the obstacle-free instance: no change at N+1, change at N+2,
  // and no further change while the level stays high or after release.
  task automatic press_t(input logic up, input logic dn, input logic [2:0] prev,
                         input logic [2:0] exp, input string name);
    t_btn_up = up; t_btn_down = dn;
    tick(2);
    n_checks++;
    if (t_player !== prev) begin
      n_fail++; $display("FAIL %s_early: got %b expected %b", name, t_player, prev);
    end
    tick(1);
    n_checks++;
    if (t_player !== exp) begin
      n_fail++; $display("FAIL %s_move: got %b expected %b", name, t_player, exp);
    end
    t_btn_up = 1'b0; t_btn_down = 1'b0;
    tick(3);
    n_checks++;
    if (t_player !== exp) begin
      n_fail++; $display("FAIL %s_once: got %b expected %b", name, t_player, exp);
    end
  endtask

  task automatic test_player();
    do_reset();
    press_t(1'b1, 1'b0, 3'b010, 3'b100, "up_mid");
    press_t(1'b1, 1'b0, 3'b100, 3'b100, "up_top");
    press_t(1'b0, 1'b1, 3'b100, 3'b010, "down_top");
    press_t(1'b1, 1'b1, 3'b010, 3'b010, "up_down");
    press_t(1'b0, 1'b1, 3'b010, 3'b001, "down_mid");
    press_t(1'b0, 1'b1, 3'b001, 3'b001, "down_bot");
  endtask

  task automatic test_scroll_spawn();
    logic [11:0] cols;
    logic [11:0] exp [6];
    int          gap [6];
    exp[0] = {3'b101, 3'b000, 3'b000, 3'b000}; gap[0] = 4;   // edge 4
    exp[1] = {3'b000, 3'b101, 3'b000, 3'b000}; gap[1] = 4;   // edge 8: forced gap (lfsr 110)
    exp[2] = {3'b101, 3'b000, 3'b101, 3'b000}; gap[2] = 4;   // edge 12
    exp[3] = {3'b000, 3'b101, 3'b000, 3'b101}; gap[3] = 4;   // edge 16
    exp[4] = {3'b000, 3'b101, 3'b000, 3'b101}; gap[4] = 8;   // edge 24
    exp[5] = {3'b000, 3'b000, 3'b101, 3'b000}; gap[5] = 4;   // edge 28: lfsr 111 -> 000
    do_reset();
    tick(3);
    n_checks++;
    if (obstacle1 !== 3'b000) begin
      n_fail++; $display("FAIL spawn_early: got %b expected 000", obstacle1);
    end
    tick(1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick(gap[i]);
      cols = {obstacle1, obstacle2, obstacle3, obstacle4};
      n_checks++;
      if (cols !== exp[i]) begin
        n_fail++; $display("FAIL scroll_%0d: got %b expected %b", i, cols, exp[i]);
      end
    end
    n_checks++;
    if (player !== 3'b010 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL scroll_alive: got %b/%b expected 010/0", player, game_over);
    end
  endtask

  // Player moves to the top lane; the 101 column reaching the player column
  // at edge 16 ends the game at edge 17. Ends at edge 117.
  task automatic test_collision_freeze();
    logic [15:0] got;
    logic [15:0] frz;
    frz = {3'b000, 3'b101, 3'b000, 3'b101, 3'b100, 1'b1};
    do_reset();
    btn_up = 1'b1;
    tick(2);
    n_checks++;
    if (player !== 3'b010) begin
      n_fail++; $display("FAIL up_latency: got %b expected 010", player);
    end
    tick(1);
    btn_up = 1'b0;
    n_checks++;
    if (player !== 3'b100) begin
      n_fail++; $display("FAIL up_move: got %b expected 100", player);
    end
    tick(13);
    n_checks++;
    if (obstacle4 !== 3'b101 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL collide_e16: got %b/%b expected 101/0", obstacle4, game_over);
    end
    tick(1);
    got = {obstacle1, obstacle2, obstacle3, obstacle4, player, game_over};
    n_checks++;
    if (got !== frz) begin
      n_fail++; $display("FAIL collide_e17: got %b expected %b", got, frz);
    end
    btn_down = 1'b1; tick(5);
    btn_down = 1'b0; tick(5);
    btn_up   = 1'b1; tick(5);
    btn_up   = 1'b0; tick(85);
    got = {obstacle1, obstacle2, obstacle3, obstacle4, player, game_over};
    n_checks++;
    if (got !== frz) begin
      n_fail++; $display("FAIL frozen_outputs: got %b expected %b", got, frz);
    end
    got = {minute_tens, minute_ones, second_tens, second_ones};
    n_checks++;
    if (got !== 16'h0001) begin
      n_fail++; $display("FAIL frozen_timer: got %h expected 0001", got);
    end
  endtask

  // Continues from the frozen game; R is the edge the restart takes effect.
  task automatic test_restart();
    logic [15:0] got;
    btn_restart = 1'b1;
    tick(2);
    n_checks++;
    if (game_over !== 1'b1) begin
      n_fail++; $display("FAIL restart_latency: got %b expected 1", game_over);
    end
    tick(1);
    btn_restart = 1'b0;
    got = {obstacle1, obstacle2, obstacle3, obstacle4, player, game_over};
    n_checks++;
    if (got !== {12'h000, 3'b010, 1'b0}) begin
      n_fail++; $display("FAIL restart_state: got %b expected %b", got, {12'h000, 3'b010, 1'b0});
    end
    got = {minute_tens, minute_ones, second_tens, second_ones};
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++; $display("FAIL restart_timer: got %h expected 0000", got);
    end
    tick(4);
    n_checks++;
    if (obstacle1 !== 3'b011) begin
      n_fail++; $display("FAIL restart_no_reseed: got %b expected 011", obstacle1);
    end
    btn_restart = 1'b1;
    tick(3);
    btn_restart = 1'b0;
    tick(1);
    got = {obstacle1, obstacle2, obstacle3, obstacle4, player, game_over};
    n_checks++;
    if (got !== {3'b000, 3'b011, 3'b000, 3'b000, 3'b010, 1'b0}) begin
      n_fail++; $display("FAIL restart_ignored: got %b expected %b", got,
                         {3'b000, 3'b011, 3'b000, 3'b000, 3'b010, 1'b0});
    end
    tick(4);
    got = {obstacle1, obstacle2, obstacle3, obstacle4, 3'b000, 1'b0};
    n_checks++;
    if (got[15:4] !== {3'b000, 3'b000, 3'b011, 3'b000} || second_ones !== 4'd1) begin
      n_fail++; $display("FAIL restart_run: got %b/%0d expected 000000011000/1", got[15:4], second_ones);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got;
    #2;
    rst_n = 1'b0;
    #1;
    got = {obstacle1, obstacle2, obstacle3, obstacle4, player, game_over};
    n_checks++;
    if (got !== {12'h000, 3'b010, 1'b0}) begin
      n_fail++; $display("FAIL async_reset_state: got %b expected %b", got, {12'h000, 3'b010, 1'b0});
    end
    got = {minute_tens, minute_ones, second_tens, second_ones};
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset_timer: got %h expected 0000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    n_checks++;
    if (obstacle1 !== 3'b101) begin
      n_fail++; $display("FAIL async_reset_reseed: got %b expected 101", obstacle1);
    end
  endtask

  // Timer instance: one second every 2 cycles, so edge k shows k/2 seconds.
  task automatic test_timer();
    logic [15:0] got;
    logic [15:0] exp [7];
    int          gap [7];
    exp[0] = 16'h0059; gap[0] = 118;
    exp[1] = 16'h0100; gap[1] = 2;
    exp[2] = 16'h1000; gap[2] = 1080;
    exp[3] = 16'h5958; gap[3] = 5997;
    exp[4] = 16'h5959; gap[4] = 1;
    exp[5] = 16'h5959; gap[5] = 2;
    exp[6] = 16'h5959; gap[6] = 10;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(gap[i]);
      got = {t_minute_tens, t_minute_ones, t_second_tens, t_second_ones};
      n_checks++;
      if (got !== exp[i]) begin
        n_fail++; $display("FAIL timer_%0d: got %h expected %h", i, got, exp[i]);
      end
    end
    n_checks++;
    if (t_game_over !== 1'b0) begin
      n_fail++; $display("FAIL timer_alive: got %b expected 0", t_game_over);
    end
  endtask

  initial begin
    test_reset();
    test_player();
    test_scroll_spawn();
    test_collision_freeze();
    test_restart();
    test_async_reset();
    test_timer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
